// File: rtl/uart8_tx.sv
// ============================================================================
//  Module   : uart8_tx
//  Brief    : 8N1 UART transmitter with a one-entry holding register for
//             back-to-back frames.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart8_tx #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_BIT_LAST = 3'd7;

  generate
    if (CLKS_PER_BIT < 2) begin : g_badRate
      $error("uart8_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state,    w_stateNext;
  logic [CNT_W-1:0] r_clkCnt,   w_clkCntNext;
  logic [2:0]       r_bitIdx,   w_bitIdxNext;
  logic [7:0]       r_shift,    w_shiftNext;
  logic [7:0]       r_hold,     w_holdNext;
  logic             r_holdFull, w_holdFullNext;
  logic             r_tx,       w_txNext;
  logic             r_busy,     w_busyNext;
  logic             r_done,     w_doneNext;

  logic             w_accept;
  logic             w_bitEnd;
  logic [2:0]       w_bitIdxInc;

  assign txReady     = txEn & ~r_holdFull;
  assign w_accept    = txStart & txReady;
  assign w_bitEnd    = (r_clkCnt == c_CNT_LAST);
  assign w_bitIdxInc = r_bitIdx + 3'd1;

  assign txBusy = r_busy;
  assign txDone = r_done;
  assign tx     = r_tx;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_clkCnt   <= '0;
      r_bitIdx   <= 3'd0;
      r_shift    <= 8'h00;
      r_hold     <= 8'h00;
      r_holdFull <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_clkCnt   <= w_clkCntNext;
      r_bitIdx   <= w_bitIdxNext;
      r_shift    <= w_shiftNext;
      r_hold     <= w_holdNext;
      r_holdFull <= w_holdFullNext;
      r_tx       <= w_txNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_clkCntNext   = r_clkCnt + 1'b1;
    w_bitIdxNext   = r_bitIdx;
    w_shiftNext    = r_shift;
    w_holdNext     = r_hold;
    w_holdFullNext = r_holdFull;
    w_txNext       = r_tx;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;

    // While a frame is on the wire an accepted byte parks in the holding register
    if (w_accept && (r_state != S_IDLE)) begin
      w_holdNext     = in;
      w_holdFullNext = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_clkCntNext = '0;
        w_bitIdxNext = 3'd0;
        w_txNext     = 1'b1;
        w_busyNext   = 1'b0;
        if (r_holdFull && txEn) begin
          w_shiftNext    = r_hold;
          w_holdFullNext = 1'b0;
          w_stateNext    = S_START;
          w_txNext       = 1'b0;
          w_busyNext     = 1'b1;
        end else if (w_accept) begin
          w_shiftNext = in;
          w_stateNext = S_START;
          w_txNext    = 1'b0;
          w_busyNext  = 1'b1;
        end
      end

      S_START: begin
        if (w_bitEnd) begin
          w_stateNext  = S_DATA;
          w_clkCntNext = '0;
          w_bitIdxNext = 3'd0;
          w_txNext     = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_bitEnd) begin
          w_clkCntNext = '0;
          if (r_bitIdx == c_BIT_LAST) begin
            w_stateNext = S_STOP;
            w_txNext    = 1'b1;
          end else begin
            w_bitIdxNext = w_bitIdxInc;
            w_txNext     = r_shift[w_bitIdxInc];
          end
        end
      end

      S_STOP: begin
        if (w_bitEnd) begin
          w_doneNext   = 1'b1;
          w_clkCntNext = '0;
          w_bitIdxNext = 3'd0;
          if (r_holdFull && txEn) begin
            w_shiftNext    = r_hold;
            w_holdFullNext = 1'b0;
            w_stateNext    = S_START;
            w_txNext       = 1'b0;
          end else if (w_accept) begin
            // Byte offered on the final stop clock bypasses the holding register
            w_shiftNext    = in;
            w_holdFullNext = 1'b0;
            w_stateNext    = S_START;
            w_txNext       = 1'b0;
          end else begin
            w_stateNext = S_IDLE;
            w_txNext    = 1'b1;
            w_busyNext  = 1'b0;
          end
        end
      end

      default: begin
        w_stateNext  = S_IDLE;
        w_clkCntNext = '0;
        w_txNext     = 1'b1;
        w_busyNext   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart8_tx.sv
// ============================================================================
//  Module   : tb_uart8_tx
//  Brief    : Scoreboard bench for uart8_tx (default rate and 4 clocks/bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart8_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstN;
  logic       txEnA, txStartA, txReadyA, txBusyA, txDoneA, txA;
  logic [7:0] inA;
  logic       txEnB, txStartB, txReadyB, txBusyB, txDoneB, txB;
  logic [7:0] inB;

  uart8_tx dutA (
    .clk(clk), .rstN(rstN), .txEn(txEnA), .txStart(txStartA), .in(inA),
    .txReady(txReadyA), .txBusy(txBusyA), .txDone(txDoneA), .tx(txA)
  );

  uart8_tx #(.CLOCK_RATE(4), .BAUD_RATE(1)) dutB (
    .clk(clk), .rstN(rstN), .txEn(txEnB), .txStart(txStartB), .in(inB),
    .txReady(txReadyB), .txBusy(txBusyB), .txDone(txDoneB), .tx(txB)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  int doneCntA = 0;
  int doneCntB = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (txDoneA === 1'b1) doneCntA <= doneCntA + 1;
    if (txDoneB === 1'b1) doneCntB <= doneCntB + 1;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       b2b;
  } exp_t;
  exp_t expQ[$];

  // Line decoder for dutB: samples mid-bit at 4 clocks/bit, drops frames cut by reset
  initial begin : monitor
    int   lastStart;
    int   st;
    logic [9:0] bits;
    bit   aborted;
    exp_t e;
    lastStart = -1000;
    forever begin
      @(negedge clk);
      if (rstN !== 1'b1 || txB !== 1'b0) continue;
      st      = cyc;
      aborted = 1'b0;
      bits    = '0;
      for (int off = 1; off <= 38; off++) begin
        @(negedge clk);
        if (rstN !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (off % 4 == 2) bits[off / 4] = txB;
      end
      if (aborted) continue;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected frame: got line bits 0x%0h, expected no frame", bits);
      end else begin
        e = expQ.pop_front();
        check("frame start bit", {31'd0, bits[0]}, 32'd0);
        check("frame data", {24'd0, bits[8:1]}, {24'd0, e.data});
        check("frame stop bit", {31'd0, bits[9]}, 32'd1);
        if (e.b2b) check("frame pitch", st - lastStart, 32'd40);
      end
      lastStart = st;
    end
  end

  task automatic sendB(input logic [7:0] b);
    @(negedge clk);
    txStartB = 1'b1;
    inB      = b;
    @(negedge clk);
    txStartB = 1'b0;
  endtask

  task automatic waitIdleB(input int maxCyc);
    int n;
    n = 0;
    while (txBusyB === 1'b1 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txBusyB !== 1'b0) begin
      errors++;
      $display("FAIL wait idle: txBusy still %b after %0d cycles, expected 0", txBusyB, n);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [9:0] frameA;
    int off;
    int d0;
    rstN = 1'b0; txEnA = 1'b1; txStartA = 1'b0; inA = 8'h00;
    txEnB = 1'b1; txStartB = 1'b0; inB = 8'h00;
    repeat (3) @(negedge clk);

    check("reset tx", {31'd0, txA}, 32'd1);
    check("reset busy", {31'd0, txBusyA}, 32'd0);
    check("reset done", {31'd0, txDoneA}, 32'd0);
    check("reset ready", {31'd0, txReadyA}, 32'd1);
    txEnB = 1'b0;
    #1 check("reset ready txEn=0", {31'd0, txReadyB}, 32'd0);
    txEnB = 1'b1;
    @(negedge clk) rstN = 1'b1;
    @(negedge clk);

    // Default rate, 0xD5: start, 1,0,1,0,1,0,1,1, stop
    frameA = 10'b1_1101_0101_0;
    txStartA = 1'b1; inA = 8'hD5;
    @(negedge clk);
    txStartA = 1'b0;
    check("t1 tx low after accept", {31'd0, txA}, 32'd0);
    check("t1 busy after accept", {31'd0, txBusyA}, 32'd1);
    off = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (625 + 1250 * k - off) @(negedge clk);
      off = 625 + 1250 * k;
      check($sformatf("t1 line bit %0d", k), {31'd0, txA}, {31'd0, frameA[k]});
    end
    repeat (12499 - off) @(negedge clk);
    check("t1 done before end", {31'd0, txDoneA}, 32'd0);
    check("t1 busy last stop clk", {31'd0, txBusyA}, 32'd1);
    @(negedge clk);
    check("t1 done pulse", {31'd0, txDoneA}, 32'd1);
    check("t1 busy fall", {31'd0, txBusyA}, 32'd0);
    @(negedge clk);
    check("t1 done one cycle", {31'd0, txDoneA}, 32'd0);

    // Queue while busy, ignored strobe while full
    d0 = doneCntB;
    expQ.push_back('{data: 8'h3C, b2b: 1'b0});
    sendB(8'h3C);
    repeat (10) @(negedge clk);
    check("t2 ready mid-frame", {31'd0, txReadyB}, 32'd1);
    expQ.push_back('{data: 8'hA5, b2b: 1'b1});
    sendB(8'hA5);
    check("t2 ready after queue", {31'd0, txReadyB}, 32'd0);
    sendB(8'hFF);
    check("t3 ready while full", {31'd0, txReadyB}, 32'd0);
    waitIdleB(200);
    repeat (2) @(negedge clk);
    check("t3 done pulses", doneCntB - d0, 32'd2);

    // txEn drop with a held byte
    expQ.push_back('{data: 8'h5A, b2b: 1'b0});
    sendB(8'h5A);
    repeat (5) @(negedge clk);
    expQ.push_back('{data: 8'h81, b2b: 1'b0});
    sendB(8'h81);
    check("t4 ready after queue", {31'd0, txReadyB}, 32'd0);
    repeat (5) @(negedge clk);
    txEnB = 1'b0;
    waitIdleB(100);
    check("t4 idle line", {31'd0, txB}, 32'd1);
    check("t4 ready txEn=0", {31'd0, txReadyB}, 32'd0);
    repeat (10) @(negedge clk);
    check("t4 held not started", {31'd0, txBusyB}, 32'd0);
    txEnB = 1'b1;
    @(negedge clk);
    check("t4 held start busy", {31'd0, txBusyB}, 32'd1);
    check("t4 held start line", {31'd0, txB}, 32'd0);
    waitIdleB(100);

    // Reset during DATA bit 3 with a byte held
    repeat (3) @(negedge clk);
    d0 = doneCntB;
    sendB(8'h96);
    sendB(8'h77);
    repeat (15) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("t5 reset tx", {31'd0, txB}, 32'd1);
    check("t5 reset busy", {31'd0, txBusyB}, 32'd0);
    check("t5 reset done", {31'd0, txDoneB}, 32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    check("t5 no done pulse", doneCntB - d0, 32'd0);
    check("t5 hold discarded", {31'd0, txReadyB}, 32'd1);
    check("t5 stays idle", {31'd0, txBusyB}, 32'd0);
    expQ.push_back('{data: 8'h01, b2b: 1'b0});
    sendB(8'h01);
    waitIdleB(100);

    // Strobe on the last STOP clock with an empty holding register
    repeat (3) @(negedge clk);
    d0 = doneCntB;
    expQ.push_back('{data: 8'hC3, b2b: 1'b0});
    sendB(8'hC3);
    repeat (38) @(negedge clk);
    expQ.push_back('{data: 8'h6E, b2b: 1'b1});
    sendB(8'h6E);
    waitIdleB(100);
    repeat (2) @(negedge clk);
    check("t6 done pulses", doneCntB - d0, 32'd2);

    repeat (5) @(negedge clk);
    check("scoreboard drained", expQ.size(), 32'd0);
    check("dutA total done", doneCntA, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart8_tx.md
Name: uart8_tx

Overview:
- 8N1 UART transmitter. It is the transmit-side counterpart of the existing 8-bit UART receive path and shares its CLOCK_RATE / BAUD_RATE conventions.
- Serialises one byte per frame as start bit, 8 data bits LSB-first, and one stop bit.
- A one-entry holding register lets the next byte be queued while a frame is on the wire, so consecutive frames go out back-to-back with no idle gap.
- Sits beside the receiver inside the Uart8 wrapper and drives the board tx pin.

Parameters:
- CLOCK_RATE, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud.
- CLKS_PER_BIT (localparam), CLOCK_RATE/BAUD_RATE integer division, clocks per serial bit; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstN  input  1  asynchronous, active-low reset.
- txEn  input  1  transmitter enable; gates acceptance and the start of new frames.
- txStart  input  1  byte-valid strobe; sampled on rising edge.
- in  input  8  byte to send; sampled when txStart is accepted.
- txReady  output  1  combinational: txEn & ~holdFull; a byte is accepted this edge if txStart=1.
- txBusy  output  1  registered; 1 from the first start-bit cycle to the last stop-bit cycle.
- txDone  output  1  registered, 1-cycle pulse after each completed stop bit.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (rstN=0, async): state=IDLE; tx=1; txBusy=0; txDone=0; holdFull=0; bit counter=0; clock counter=0. txReady follows txEn.
- States: IDLE, START, DATA, STOP.
  - Each of START and STOP lasts exactly CLKS_PER_BIT clocks.
  - DATA lasts 8*CLKS_PER_BIT clocks; the bit index increments 0..7 every CLKS_PER_BIT clocks.
- Clock counter: counts 0..CLKS_PER_BIT-1, resets on every bit boundary and on any state entry.
- Accept (txStart & txReady at an edge):
  - In IDLE with holdFull=0: `in` loads the shift register directly and the FSM goes to START on the same edge. From the next cycle tx=0 and txBusy=1 (latency 1 clock). holdFull stays 0.
  - Otherwise (frame in progress): `in` loads the holding register; holdFull=1, so txReady=0.
- txStart while txReady=0: ignored; the holding register is not overwritten.
- Line levels:
  - START drives tx=0.
  - DATA drives tx=shift[bitIdx], LSB first.
  - STOP drives tx=1.
- End of STOP (last STOP clock), txDone=1 for the following cycle, then:
  - If holdFull & txEn: the holding register moves to the shift register, holdFull=0, state=START. tx goes 1->0 with no idle cycle and txBusy stays 1.
  - Else if a txStart is accepted on this same edge (holdFull=0): the new byte goes straight to START; txBusy stays 1.
  - Else: state=IDLE, txBusy=0, tx=1.
- IDLE with holdFull=1 and txEn=1: start the held byte on the next edge (move to shift register, clear holdFull, go to START).
- txEn=0:
  - A frame in progress always completes unchanged.
  - No new frame starts; txReady=0.
  - A held byte is retained until txEn returns high.
- Reset mid-frame: tx returns to 1 immediately. The frame is abandoned and the held byte is discarded.
- No parity and no break generation; tx never drops low outside START or a 0 data bit.

Test Plan:
1. Default params, txEn=1, send 0xD5 from IDLE -> tx low one clock after accept for 1250 clocks, then bits 1,0,1,0,1,0,1,1 each 1250 clocks, stop high 1250 clocks. txDone pulses once at 12500 clocks after the start edge; txBusy falls the same cycle.
2. CLOCK_RATE=4, BAUD_RATE=1: send 0x3C, then queue 0xA5 mid-frame -> txReady=0 after the queue. The second start bit begins on the clock right after the first stop bit ends (frames at 40-clock pitch, no idle cycle). Line bits LSB-first are 0,0,1,1,1,1,0,0 then 1,0,1,0,0,1,0,1.
3. While holdFull=1, pulse txStart with 0xFF -> ignored. The second frame carries the queued byte; only two txDone pulses occur.
4. Queue a byte, drop txEn before the first frame ends -> first frame completes and the line idles high with txBusy=0. Raise txEn -> the held byte starts one clock later.
5. Assert rstN=0 during DATA bit 3 -> tx=1, txBusy=0 immediately, no txDone. After release, a new byte 0x01 transmits correctly.
6. txStart asserted on the last STOP clock with an empty holding register -> back-to-back frame with no idle gap and the correct byte on the line.
